// File: rtl/addf_arbiter.sv
// addf_arbiter: shares one combinational single-precision adder (addf) between
// two requesters. A granted operand pair is registered and held on addf for LAT
// cycles. The registered sum is then returned on a valid/ready port together
// with the id of the requester that issued it.
// Build option: define ADDF_ARB_FIXED_PRIO_EN for fixed priority, where port 0
// wins every tie. By default ties are resolved round-robin.

// addf: combinational IEEE-754 single-precision adder with round-to-nearest-even.
// Denormal inputs are flushed to zero, underflowing results become +0, and
// overflowing results saturate to infinity. An exact zero sum is always 32'h0.
module addf (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  logic        a_big;
  logic [31:0] big, sml;
  logic [7:0]  e_big, e_sml, d;
  logic [23:0] m_big, m_sml;
  logic [26:0] x_big, x_sml, x_shift;
  logic        sticky;
  logic [27:0] raw;
  logic [26:0] norm;
  logic [4:0]  lz;
  logic [9:0]  e_res;
  logic [24:0] mant;
  logic        rnd_up;

  // Align the smaller magnitude with guard/round/sticky bits, add or subtract, normalise, then round.
  always_comb begin
    a_big   = (a[30:0] >= b[30:0]);
    big     = a_big ? a : b;
    sml     = a_big ? b : a;
    e_big   = big[30:23];
    e_sml   = sml[30:23];
    m_big   = (e_big != 8'd0) ? {1'b1, big[22:0]} : 24'd0;
    m_sml   = (e_sml != 8'd0) ? {1'b1, sml[22:0]} : 24'd0;
    d       = e_big - e_sml;
    x_big   = {m_big, 3'b000};
    x_shift = 27'd0;
    sticky  = 1'b0;
    if (d >= 8'd27) begin
      sticky = (m_sml != 24'd0);
    end else begin
      x_shift = {m_sml, 3'b000} >> d;
      sticky  = (({m_sml, 3'b000} & ((27'd1 << d) - 27'd1)) != 27'd0);
    end
    x_sml = x_shift | {26'd0, sticky};

    if (big[31] == sml[31]) raw = {1'b0, x_big} + {1'b0, x_sml};
    else                    raw = {1'b0, x_big} - {1'b0, x_sml};

    // Bring the leading one to bit 26; a carry-out needs a single right shift.
    e_res = {2'b00, e_big};
    lz    = 5'd0;
    if (raw[27]) begin
      norm  = raw[27:1] | {26'd0, raw[0]};
      e_res = e_res + 10'd1;
    end else begin
      for (int i = 0; i < 27; i++) begin
        if (raw[i]) lz = 5'(26 - i);
      end
      norm  = raw[26:0] << lz;
      e_res = e_res - {5'd0, lz};
    end

    rnd_up = norm[2] && (norm[1] || norm[0] || norm[3]);
    mant   = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    if (mant[24]) begin
      mant  = mant >> 1;
      e_res = e_res + 10'd1;
    end

    // mant[23] is clear only when the true sum is zero.
    if (!mant[23] || e_res[9] || (e_res == 10'd0)) s = 32'h0;
    else if (e_res >= 10'd255)                      s = {big[31], 8'hFF, 23'd0};
    else                                            s = {big[31], e_res[7:0], mant[22:0]};
  end
endmodule

module addf_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic [31:0] in0_a,
  input  logic [31:0] in0_b,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [31:0] in1_a,
  input  logic [31:0] in1_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_id,
  output logic        busy
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t        state_q;
  logic [31:0]   opa_q, opb_q, out_sum_q;
  logic          id_q, out_valid_q, out_id_q, busy_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    req_valid, grant;
  logic [31:0]   addf_s;
`ifndef ADDF_ARB_FIXED_PRIO_EN
  logic          last_q;
`endif

  assign req_valid = {in1_valid, in0_valid};
  assign in0_ready = grant[0];
  assign in1_ready = grant[1];
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_id    = out_id_q;
  assign busy      = busy_q;

  // The registered operands are the only thing ever presented to the shared adder.
  addf u_addf (
    .a(opa_q),
    .b(opb_q),
    .s(addf_s)
  );

  // Combinational grant: offered only in IDLE, out of reset, to a requester that is valid.
  always_comb begin
    grant = 2'b00;
    if (!rst && (state_q == IDLE)) begin
`ifdef ADDF_ARB_FIXED_PRIO_EN
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
`else
      if (&req_valid) grant = last_q ? 2'b01 : 2'b10;
      else            grant = req_valid;
`endif
    end
  end

  // Capture the granted operands, count down the adder settle time, then hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      opa_q       <= 32'd0;
      opb_q       <= 32'd0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= 32'd0;
      out_id_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifndef ADDF_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            opa_q   <= grant[1] ? in1_a : in0_a;
            opb_q   <= grant[1] ? in1_b : in0_b;
            id_q    <= grant[1];
`ifndef ADDF_ARB_FIXED_PRIO_EN
            last_q  <= grant[1];
`endif
            cnt_q   <= CW'(LAT - 1);
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            out_sum_q   <= addf_s;
            out_id_q    <= id_q;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
